membus_rr_arbiter: RTL

Parametrised N-master to one-slave Membus arbiter that replaces the fixed two-way instruction/data mux in front of the MMIO controller. It grants one master per cycle under fixed-priority or round-robin policy and locks the grant while the slave stalls. It records each accepted request's owner in an in-order tag FIFO so several requests can be outstanding, then routes each response back to its owner. For masters flagged narrow, it extracts the 32-bit read lane.

---
 rtl/membus_rr_arbiter.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/membus_rr_arbiter.sv
// N-master to one-slave Membus arbiter: fixed-priority or round-robin grant, grant lock
// during slave stalls, in-order owner tag FIFO for outstanding requests, narrow read-lane extraction.
module membus_rr_arbiter #(
    parameter int N_MASTERS       = 2,
    parameter int ADDR_WIDTH      = 64,
    parameter int DATA_WIDTH      = 64,
    parameter int MAX_OUTSTANDING = 2,
    parameter int RR_MODE         = 1,
    parameter logic [N_MASTERS-1:0] NARROW_MASK = 'b10
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic [N_MASTERS-1:0]                   m_valid,
    output logic [N_MASTERS-1:0]                   m_ready,
    input  logic [N_MASTERS-1:0][ADDR_WIDTH-1:0]   m_addr,
    input  logic [N_MASTERS-1:0]                   m_wen,
    input  logic [N_MASTERS-1:0][DATA_WIDTH-1:0]   m_wdata,
    input  logic [N_MASTERS-1:0][DATA_WIDTH/8-1:0] m_wmask,
    output logic [N_MASTERS-1:0]                   m_rvalid,
    output logic [DATA_WIDTH-1:0]                  m_rdata,
    output logic                                   s_valid,
    output logic [ADDR_WIDTH-1:0]                  s_addr,
    output logic                                   s_wen,
    output logic [DATA_WIDTH-1:0]                  s_wdata,
    output logic [DATA_WIDTH/8-1:0]                s_wmask,
    input  logic                                   s_ready,
    input  logic                                   s_rvalid,
    input  logic [DATA_WIDTH-1:0]                  s_rdata,
    output logic [$clog2(MAX_OUTSTANDING+1)-1:0]   outstanding,
    output logic                                   err_unexpected
);

    localparam int IDX_W = $clog2(N_MASTERS);
    localparam int PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);

    logic [IDX_W-1:0] rr_ptr_reg;
    logic [IDX_W-1:0] lock_idx_reg;
    logic             lock_reg;
    logic [IDX_W-1:0] grant;
    logic [IDX_W-1:0] rr_ptr_next;

    logic [IDX_W-1:0] tag_idx_mem  [MAX_OUTSTANDING];
    logic             tag_lane_mem [MAX_OUTSTANDING];
    logic [PTR_W-1:0] wr_ptr_reg;
    logic [PTR_W-1:0] rd_ptr_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic             err_reg;

    logic             full;
    logic             accept;
    logic             pop;
    logic [IDX_W-1:0] head_idx;
    logic             head_lane;
    logic [31:0]      lane_data;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(MAX_OUTSTANDING - 1)) ? '0 : p + 1'b1;
    endfunction

    // A locked grant wins; otherwise search starts at rr_ptr (round-robin) or at index 0.
    always_comb begin
        int   cand;
        logic found;
        cand  = 0;
        found = 1'b0;
        grant = '0;
        if (lock_reg) begin
            grant = lock_idx_reg;
        end else begin
            for (int k = 0; k < N_MASTERS; k++) begin
                cand = (RR_MODE != 0) ? int'(rr_ptr_reg) + k : k;
                if (cand >= N_MASTERS) cand = cand - N_MASTERS;
                if (!found && m_valid[IDX_W'(cand)]) begin
                    grant = IDX_W'(cand);
                    found = 1'b1;
                end
            end
        end
    end

    assign rr_ptr_next = (grant == IDX_W'(N_MASTERS - 1)) ? '0 : grant + 1'b1;

    // Full blocks requests even when a pop happens this cycle: no s_rvalid -> s_ready path.
    assign full    = (cnt_reg == CNT_W'(MAX_OUTSTANDING));
    assign s_valid = (|m_valid) && !full;
    assign s_addr  = m_addr[grant];
    assign s_wen   = m_wen[grant];
    assign s_wdata = m_wdata[grant];
    assign s_wmask = m_wmask[grant];
    assign accept  = s_valid && s_ready;
    assign pop     = s_rvalid && (cnt_reg != '0);

    assign head_idx  = tag_idx_mem[rd_ptr_reg];
    assign head_lane = tag_lane_mem[rd_ptr_reg];
    assign lane_data = head_lane ? s_rdata[63:32] : s_rdata[31:0];
    assign m_rdata   = NARROW_MASK[head_idx] ? {{(DATA_WIDTH-32){1'b0}}, lane_data} : s_rdata;

    generate
        for (genvar gi = 0; gi < N_MASTERS; gi++) begin : g_master
            assign m_ready[gi]  = (grant == IDX_W'(gi)) && s_ready && !full;
            assign m_rvalid[gi] = pop && (head_idx == IDX_W'(gi));
        end
    endgenerate

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rr_ptr_reg   <= '0;
            lock_reg     <= 1'b0;
            lock_idx_reg <= '0;
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            cnt_reg      <= '0;
            err_reg      <= 1'b0;
        end else begin
            if (accept) begin
                lock_reg   <= 1'b0;
                rr_ptr_reg <= rr_ptr_next;
                wr_ptr_reg <= ptr_inc(wr_ptr_reg);
            end else if (s_valid) begin
                lock_reg     <= 1'b1;
                lock_idx_reg <= grant;
            end
            if (pop) rd_ptr_reg <= ptr_inc(rd_ptr_reg);
            case ({accept, pop})
                2'b10:   cnt_reg <= cnt_reg + 1'b1;
                2'b01:   cnt_reg <= cnt_reg - 1'b1;
                default: cnt_reg <= cnt_reg;
            endcase
            if (s_rvalid && (cnt_reg == '0)) err_reg <= 1'b1;
        end
    end

    // Tag payload needs no reset: only entries between the pointers are ever read.
    always_ff @(posedge clk) begin
        if (accept) begin
            tag_idx_mem[wr_ptr_reg]  <= grant;
            tag_lane_mem[wr_ptr_reg] <= s_addr[2];
        end
    end

    assign outstanding    = cnt_reg;
    assign err_unexpected = err_reg;

endmodule
